mac_block_pipe: RTL

//  Parametrised, valid-qualified MAC tile; next generation of the single-stage fabric MAC.
//  - Multiplies up to LANES operand slices by a shared B.
//  - Adds the slices shifted by lane weight to form a wide product.
//  - Optionally accumulates the product, with a per-beat init load and optional saturation.
//  - Pipelined 2 cycles with valid in/out and a sticky overflow flag.
//  - Sits in the MAC cluster; lane 0 is forwarded combinationally for chaining.

---
 rtl/mac_block_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/mac_block_pipe.sv
// Two-stage valid-qualified MAC tile: lane-weighted multiply of A by a shared B,
// then an optional accumulate with init load, saturation and a sticky overflow flag.
module mac_block_pipe #(
    parameter int MIN_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [LANES*MIN_WIDTH-1:0]   A,
    input  logic [MIN_WIDTH-1:0]         B,
    input  logic [1:0]                   mode,
    input  logic                         acc_en,
    input  logic                         init_load,
    input  logic [ACC_WIDTH-1:0]         init_val,
    input  logic                         sat_en,
    output logic [MIN_WIDTH-1:0]         A_fwd,
    output logic                         out_valid,
    output logic [ACC_WIDTH-1:0]         C,
    output logic                         ovf
);

    localparam int PW = (LANES + 1) * MIN_WIDTH;
    // One extra bit above the wider of product/accumulator so the overflow carry is visible.
    localparam int SW = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 1;

    logic [PW-1:0]        prod;
    logic [PW-1:0]        p1;
    logic                 v1;
    logic                 acc_en1;
    logic                 init_load1;
    logic                 sat_en1;
    logic [ACC_WIDTH-1:0] init_val1;
    logic [ACC_WIDTH-1:0] acc;
    int                   active_lanes;
    logic [SW-1:0]        base_ext;
    logic [SW-1:0]        sum;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] result;

    assign A_fwd = A[MIN_WIDTH-1:0];

    always_comb begin
        case (mode)
            2'b00:   active_lanes = 1;
            2'b01:   active_lanes = 2;
            2'b10:   active_lanes = 4;
            default: active_lanes = 0;
        endcase
    end

    always_comb begin
        prod = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < active_lanes) begin
                prod = prod + ((PW'(A[k*MIN_WIDTH +: MIN_WIDTH]) * PW'(B)) << (k * MIN_WIDTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p1         <= prod;
                acc_en1    <= acc_en;
                init_load1 <= init_load;
                init_val1  <= init_val;
                sat_en1    <= sat_en;
            end
        end
    end

    // Multiply-only beats reuse the same clamp/wrap path with a zero base.
    always_comb begin
        base_ext = init_load1 ? SW'(init_val1) : SW'(acc);
        sum      = acc_en1 ? (base_ext + SW'(p1)) : SW'(p1);
        ovf_now  = |sum[SW-1:ACC_WIDTH];
        result   = (ovf_now && sat_en1) ? '1 : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            C         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                C <= result;
                if (acc_en1) begin
                    acc <= result;
                end else if (init_load1) begin
                    acc <= init_val1;
                end
                if (ovf_now) begin
                    ovf <= 1'b1;
                end else if (init_load1) begin
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule
